// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encodings,
// exception cause codes and the NOP encoding shown on the decode port.
package if_fetch_ctrl_pkg;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_XLATE  = 3'd1;
    localparam logic [2:0] ST_IC_REQ = 3'd2;
    localparam logic [2:0] ST_KILL   = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;
    localparam logic [2:0] ST_SLEEP  = 3'd5;

    typedef enum logic [3:0] {
        EXC_MISALIGNED = 4'd0,
        EXC_PAGE_FAULT = 4'd12
    } exc_cause_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch controller bus bundle: redirect/sleep controls, MMU, icache and decode.
// master = the fetch controller, slave = the surrounding core/memory side.
interface if_fetch_ctrl_if #(parameter int XLEN = 32);

    logic            csr_new_pc_req;
    logic [XLEN-1:0] csr_pc_new;
    logic            exe_new_pc_req;
    logic [XLEN-1:0] exe_pc_new;
    logic            wfi_req;
    logic            irq_req;
    logic            if_stall;

    logic            mmu_req;
    logic [XLEN-1:0] mmu_vaddr;
    logic            mmu_hit;
    logic [XLEN-1:0] mmu_paddr;
    logic            mmu_page_fault;

    logic            ic_req;
    logic [XLEN-1:0] ic_addr;
    logic            ic_ack;
    logic [31:0]     ic_rdata;

    logic            id_valid;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_exc_valid;
    logic [3:0]      id_exc_cause;

    modport master (
        input  csr_new_pc_req, csr_pc_new, exe_new_pc_req, exe_pc_new,
        input  wfi_req, irq_req, if_stall,
        output mmu_req, mmu_vaddr,
        input  mmu_hit, mmu_paddr, mmu_page_fault,
        output ic_req, ic_addr,
        input  ic_ack, ic_rdata,
        output id_valid, id_instr, id_pc, id_exc_valid, id_exc_cause
    );

    modport slave (
        output csr_new_pc_req, csr_pc_new, exe_new_pc_req, exe_pc_new,
        output wfi_req, irq_req, if_stall,
        input  mmu_req, mmu_vaddr,
        output mmu_hit, mmu_paddr, mmu_page_fault,
        input  ic_req, ic_addr,
        output ic_ack, ic_rdata,
        input  id_valid, id_instr, id_pc, id_exc_valid, id_exc_cause
    );

endinterface

// File: rtl/if_fetch_ctrl_redirect_arb.sv
// Combinational redirect priority: CSR > EXE > WFI. A WFI-only request keeps
// the current pc and raises the sleep flag.
module if_redirect_arb #(
    parameter int XLEN = 32
) (
    input  logic            csr_req,
    input  logic [XLEN-1:0] csr_pc,
    input  logic            exe_req,
    input  logic [XLEN-1:0] exe_pc,
    input  logic            wfi_req,
    input  logic [XLEN-1:0] cur_pc,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    output logic            redir_sleep
);

    always_comb begin
        redir_valid = csr_req | exe_req | wfi_req;
        redir_sleep = wfi_req & ~csr_req & ~exe_req;
        if (csr_req)      redir_pc = csr_pc;
        else if (exe_req) redir_pc = exe_pc;
        else              redir_pc = cur_pc;
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Non-pipelined instruction fetch FSM: translate pc, fetch from icache, present
// to decode. Redirects that land on an outstanding icache request drain it first.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input logic            clk,
    input logic            rst_n,
    if_fetch_ctrl_if.master bus
);

    logic [2:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] paddr;
    logic            pend_sleep;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] id_pc_q;
    logic            exc_v_q;
    logic [3:0]      exc_c_q;

    logic            redir_valid;
    logic            redir_sleep;
    logic [XLEN-1:0] redir_pc;
    logic            pc_redir;

    if_redirect_arb #(.XLEN(XLEN)) u_arb (
        .csr_req     (bus.csr_new_pc_req),
        .csr_pc      (bus.csr_pc_new),
        .exe_req     (bus.exe_new_pc_req),
        .exe_pc      (bus.exe_pc_new),
        .wfi_req     (bus.wfi_req),
        .cur_pc      (pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_sleep (redir_sleep)
    );

    assign pc_redir = redir_valid & ~redir_sleep;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RESET;
            pc         <= PC_RESET;
            paddr      <= '0;
            pend_sleep <= 1'b0;
            instr_q    <= INSTR_NOP;
            id_pc_q    <= PC_RESET;
            exc_v_q    <= 1'b0;
            exc_c_q    <= '0;
        end else begin
            case (state)
                ST_RESET: state <= ST_XLATE;

                ST_XLATE: begin
                    if (redir_valid) begin
                        pc    <= redir_pc;
                        state <= redir_sleep ? ST_SLEEP : ST_XLATE;
                    end else if (!word_aligned(pc[1:0])) begin
                        instr_q <= INSTR_NOP;
                        id_pc_q <= pc;
                        exc_v_q <= 1'b1;
                        exc_c_q <= EXC_MISALIGNED;
                        state   <= ST_OUT;
                    end else if (bus.mmu_page_fault) begin
                        instr_q <= INSTR_NOP;
                        id_pc_q <= pc;
                        exc_v_q <= 1'b1;
                        exc_c_q <= EXC_PAGE_FAULT;
                        state   <= ST_OUT;
                    end else if (bus.mmu_hit) begin
                        paddr <= bus.mmu_paddr;
                        state <= ST_IC_REQ;
                    end
                end

                ST_IC_REQ: begin
                    if (redir_valid) begin
                        // An unacked request must still be drained before moving on.
                        pc         <= redir_pc;
                        pend_sleep <= redir_sleep;
                        if (bus.ic_ack) state <= redir_sleep ? ST_SLEEP : ST_XLATE;
                        else            state <= ST_KILL;
                    end else if (bus.ic_ack) begin
                        instr_q <= bus.ic_rdata;
                        id_pc_q <= pc;
                        exc_v_q <= 1'b0;
                        exc_c_q <= '0;
                        state   <= ST_OUT;
                    end
                end

                ST_KILL: begin
                    if (redir_valid) begin
                        pc         <= redir_pc;
                        pend_sleep <= redir_sleep;
                    end
                    if (bus.ic_ack)
                        state <= (redir_valid ? redir_sleep : pend_sleep) ? ST_SLEEP : ST_XLATE;
                end

                ST_OUT: begin
                    if (redir_valid) begin
                        pc    <= redir_pc;
                        state <= redir_sleep ? ST_SLEEP : ST_XLATE;
                    end else if (!bus.if_stall) begin
                        pc    <= pc + XLEN'(4);
                        state <= ST_XLATE;
                    end
                end

                ST_SLEEP: begin
                    if (pc_redir) begin
                        pc    <= redir_pc;
                        state <= ST_XLATE;
                    end else if (bus.irq_req) begin
                        state <= ST_XLATE;
                    end
                end

                default: state <= ST_RESET;
            endcase
        end
    end

    assign bus.mmu_req      = (state == ST_XLATE) && word_aligned(pc[1:0]);
    assign bus.mmu_vaddr    = (state == ST_XLATE) ? pc : '0;
    assign bus.ic_req       = (state == ST_IC_REQ) || (state == ST_KILL);
    assign bus.ic_addr      = paddr;
    assign bus.id_valid     = (state == ST_OUT);
    assign bus.id_instr     = instr_q;
    assign bus.id_pc        = id_pc_q;
    assign bus.id_exc_valid = exc_v_q;
    assign bus.id_exc_cause = exc_c_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a per-cycle vector table for reset, the
// basic fetch stream and redirects, then hand sequences for multi-cycle cases.
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;

    if_fetch_ctrl_if #(.XLEN(32)) bus ();

    if_fetch_ctrl #(.XLEN(32), .PC_RESET(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory-side responder: fixed translation offset, data tagged by address.
    assign bus.mmu_paddr = bus.mmu_vaddr + 32'h0000_1000;
    assign bus.ic_rdata  = 32'hA000_0000 | bus.ic_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rst, csr, csr_pc, exe, exe_pc;
        logic [31:0] mreq, vaddr, ireq, iaddr, vld, instr, pc, ev, ec;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic [31:0] rst, csr, csr_pc, exe, exe_pc,
        input logic [31:0] mreq, vaddr, ireq, iaddr, vld, instr, pc, ev, ec);
        vec_t v;
        v.rst = rst; v.csr = csr; v.csr_pc = csr_pc; v.exe = exe; v.exe_pc = exe_pc;
        v.mreq = mreq; v.vaddr = vaddr; v.ireq = ireq; v.iaddr = iaddr; v.vld = vld;
        v.instr = instr; v.pc = pc; v.ev = ev; v.ec = ec;
        tbl.push_back(v);
    endfunction

    task automatic chk_vec(input int i, input vec_t v);
        chk($sformatf("v%0d_mmu_req", i),   32'(bus.mmu_req),      v.mreq);
        chk($sformatf("v%0d_mmu_vaddr", i), bus.mmu_vaddr,         v.vaddr);
        chk($sformatf("v%0d_ic_req", i),    32'(bus.ic_req),       v.ireq);
        chk($sformatf("v%0d_ic_addr", i),   bus.ic_addr,           v.iaddr);
        chk($sformatf("v%0d_id_valid", i),  32'(bus.id_valid),     v.vld);
        chk($sformatf("v%0d_id_instr", i),  bus.id_instr,          v.instr);
        chk($sformatf("v%0d_id_pc", i),     bus.id_pc,             v.pc);
        chk($sformatf("v%0d_exc_valid", i), 32'(bus.id_exc_valid), v.ev);
        chk($sformatf("v%0d_exc_cause", i), 32'(bus.id_exc_cause), v.ec);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.csr_new_pc_req = 1'b0; bus.csr_pc_new = '0;
        bus.exe_new_pc_req = 1'b0; bus.exe_pc_new = '0;
        bus.wfi_req = 1'b0; bus.irq_req = 1'b0; bus.if_stall = 1'b0;
        bus.mmu_hit = 1'b1; bus.mmu_page_fault = 1'b0; bus.ic_ack = 1'b1;

        //  rst csr cpc   exe epc    mreq vaddr ireq iaddr   vld instr         pc     ev ec
        add(0, 0, 0,     0, 0,      0, 0,     0, 0,      0, NOP,          0,     0, 0);
        add(0, 0, 0,     0, 0,      0, 0,     0, 0,      0, NOP,          0,     0, 0);
        add(1, 0, 0,     0, 0,      0, 0,     0, 0,      0, NOP,          0,     0, 0);
        add(1, 0, 0,     0, 0,      1, 0,     0, 0,      0, NOP,          0,     0, 0);
        add(1, 0, 0,     0, 0,      0, 0,     1, 'h1000, 0, NOP,          0,     0, 0);
        add(1, 0, 0,     0, 0,      0, 0,     0, 'h1000, 1, 'hA000_1000,  0,     0, 0);
        add(1, 0, 0,     0, 0,      1, 4,     0, 'h1000, 0, 'hA000_1000,  0,     0, 0);
        add(1, 0, 0,     0, 0,      0, 0,     1, 'h1004, 0, 'hA000_1000,  0,     0, 0);
        add(1, 0, 0,     0, 0,      0, 0,     0, 'h1004, 1, 'hA000_1004,  4,     0, 0);
        add(1, 0, 0,     0, 0,      1, 8,     0, 'h1004, 0, 'hA000_1004,  4,     0, 0);
        add(1, 0, 0,     0, 0,      0, 0,     1, 'h1008, 0, 'hA000_1004,  4,     0, 0);
        add(1, 1, 'h20,  1, 'h40,   0, 0,     0, 'h1008, 1, 'hA000_1008,  8,     0, 0);
        add(1, 0, 0,     0, 0,      1, 'h20,  0, 'h1008, 0, 'hA000_1008,  8,     0, 0);
        add(1, 0, 0,     0, 0,      0, 0,     1, 'h1020, 0, 'hA000_1008,  8,     0, 0);
        add(1, 1, 'h2,   0, 0,      0, 0,     0, 'h1020, 1, 'hA000_1020,  'h20,  0, 0);
        add(1, 0, 0,     0, 0,      0, 2,     0, 'h1020, 0, 'hA000_1020,  'h20,  0, 0);
        add(1, 0, 0,     1, 'h40,   0, 0,     0, 'h1020, 1, NOP,          2,     1, 0);
        add(1, 0, 0,     0, 0,      1, 'h40,  0, 'h1020, 0, NOP,          2,     1, 0);
        add(1, 0, 0,     0, 0,      0, 0,     1, 'h1040, 0, NOP,          2,     1, 0);
        add(1, 0, 0,     0, 0,      0, 0,     0, 'h1040, 1, 'hA000_1040,  'h40,  0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n              = tbl[i].rst[0];
            bus.csr_new_pc_req = tbl[i].csr[0];
            bus.csr_pc_new     = tbl[i].csr_pc;
            bus.exe_new_pc_req = tbl[i].exe[0];
            bus.exe_pc_new     = tbl[i].exe_pc;
            #1;
            chk_vec(i, tbl[i]);
        end
        bus.csr_new_pc_req = 1'b0;
        bus.exe_new_pc_req = 1'b0;

        // Redirect while the icache request is outstanding: drain, discard, refetch.
        @(negedge clk); bus.ic_ack = 1'b0;
        chk("kill_xlate_vaddr", bus.mmu_vaddr, 32'h44);
        @(negedge clk);
        chk("kill_icreq", 32'(bus.ic_req), 1);
        chk("kill_icaddr0", bus.ic_addr, 32'h1044);
        bus.exe_new_pc_req = 1'b1; bus.exe_pc_new = 32'h40;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); bus.exe_new_pc_req = 1'b0;
            chk($sformatf("kill_hold_req%0d", k), 32'(bus.ic_req), 1);
            chk($sformatf("kill_hold_addr%0d", k), bus.ic_addr, 32'h1044);
            chk($sformatf("kill_no_valid%0d", k), 32'(bus.id_valid), 0);
            if (k == 3) bus.ic_ack = 1'b1;
        end
        @(negedge clk);
        chk("kill_refetch_vaddr", bus.mmu_vaddr, 32'h40);
        chk("kill_refetch_mreq", 32'(bus.mmu_req), 1);
        @(negedge clk);
        chk("kill_refetch_icaddr", bus.ic_addr, 32'h1040);
        @(negedge clk);
        chk("kill_out_valid", 32'(bus.id_valid), 1);
        chk("kill_out_pc", bus.id_pc, 32'h40);
        chk("kill_out_instr", bus.id_instr, 32'hA000_1040);

        // Decode stall holds the output and delays the pc increment.
        @(negedge clk);
        chk("stall_xlate_vaddr", bus.mmu_vaddr, 32'h44);
        @(negedge clk);
        @(negedge clk); bus.if_stall = 1'b1;
        chk("stall_out_valid", 32'(bus.id_valid), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("stall_valid%0d", k), 32'(bus.id_valid), 1);
            chk($sformatf("stall_pc%0d", k), bus.id_pc, 32'h44);
            chk($sformatf("stall_instr%0d", k), bus.id_instr, 32'hA000_1044);
            chk($sformatf("stall_no_mreq%0d", k), 32'(bus.mmu_req), 0);
            if (k == 3) bus.if_stall = 1'b0;
        end

        // Page fault wins over hit and produces no icache request.
        @(negedge clk); bus.mmu_page_fault = 1'b1;
        chk("pf_xlate_vaddr", bus.mmu_vaddr, 32'h48);
        chk("pf_xlate_noic", 32'(bus.ic_req), 0);
        @(negedge clk); bus.mmu_page_fault = 1'b0;
        chk("pf_valid", 32'(bus.id_valid), 1);
        chk("pf_exc_valid", 32'(bus.id_exc_valid), 1);
        chk("pf_exc_cause", 32'(bus.id_exc_cause), 12);
        chk("pf_pc", bus.id_pc, 32'h48);
        chk("pf_noic", 32'(bus.ic_req), 0);

        // WFI sleeps with no requests; irq resumes at the same pc.
        @(negedge clk); bus.wfi_req = 1'b1;
        chk("wfi_xlate_vaddr", bus.mmu_vaddr, 32'h4C);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); bus.wfi_req = 1'b0;
            chk($sformatf("sleep_mreq%0d", k), 32'(bus.mmu_req), 0);
            chk($sformatf("sleep_ireq%0d", k), 32'(bus.ic_req), 0);
            chk($sformatf("sleep_vld%0d", k), 32'(bus.id_valid), 0);
            if (k == 4) bus.irq_req = 1'b1;
        end
        @(negedge clk); bus.irq_req = 1'b0;
        chk("wake_mreq", 32'(bus.mmu_req), 1);
        chk("wake_vaddr", bus.mmu_vaddr, 32'h4C);
        @(negedge clk);
        chk("wake_icaddr", bus.ic_addr, 32'h104C);
        @(negedge clk);
        chk("wake_valid", 32'(bus.id_valid), 1);
        chk("wake_pc", bus.id_pc, 32'h4C);

        // Reset in the middle of an unacked icache request abandons it.
        @(negedge clk); bus.ic_ack = 1'b0;
        @(negedge clk);
        chk("rst_mid_ireq", 32'(bus.ic_req), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ireq_low", 32'(bus.ic_req), 0);
        chk("rst_mid_icaddr", bus.ic_addr, 32'h0);
        chk("rst_mid_pc", bus.id_pc, 32'h0);
        chk("rst_mid_instr", bus.id_instr, NOP);
        rst_n = 1'b1; bus.ic_ack = 1'b1;
        @(negedge clk);
        chk("rst_after_mreq", 32'(bus.mmu_req), 1);
        chk("rst_after_vaddr", bus.mmu_vaddr, 32'h0);
        @(negedge clk);
        chk("rst_after_icaddr", bus.ic_addr, 32'h1000);
        @(negedge clk);
        chk("rst_after_valid", 32'(bus.id_valid), 1);
        chk("rst_after_instr", bus.id_instr, 32'hA000_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
